bist_counter_ctrl: RTL and testbench
====================================

// Module: bist_counter_ctrl
// PURPOSE
//  BIST controller for the fast 6:3 counter (compressor built from full adders).
//  - On start: applies all 64 six-bit patterns to the counter under test.
//  - Compares each 3-bit response against an internal popcount golden model.
//  - Reports pass/fail, error count and first failing pattern.
//  - Sits beside the counter; test_mode steers the counter input mux to tpg_out.
// PARAMETERS
//  DUT_LAT  1  cycles from tpg_out change to valid dut_resp; legal 0..4
// PORTS
//  clk         in   1  sole clock, rising edge
//  rst         in   1  asynchronous, active-high reset
//  start       in   1  sampled in IDLE/DONE only; launches a test run
//  dut_resp    in   3  {carry2,carry1,sum} from 6:3 counter under test
//  test_mode   out  1  high while busy; selects tpg_out into the DUT
//  tpg_out     out  6  current test pattern
//  busy        out  1  run in progress (RUN or DRAIN)
//  done        out  1  sticky; high in DONE until next accepted start
//  pass        out  1  valid when done: err_cnt==0 (and signatures match, see CONFIGURATION)
//  err_cnt     out  7  mismatching responses this run (0..64)
//  first_fail  out  6  pattern of first mismatch; 0 if none
//  signature   out  3  MISR of dut_resp (BIST_MISR_EN only, else 3'b000)
// BEHAVIOUR
//  - Reset (async): state=IDLE; all outputs 0; pattern counter, delay line and MISRs 0.
//  - FSM states:
//    - IDLE --start--> RUN
//    - RUN --pattern 63 issued--> DRAIN (or straight to DONE if DUT_LAT==0)
//    - DRAIN --DUT_LAT cycles--> DONE
//    - DONE --start--> RUN
//  - Start sampling: edge E0 samples start=1 in IDLE/DONE. At E0:
//    - err_cnt, first_fail, pass, done and the MISRs clear.
//    - Pattern counter loads 0.
//  - RUN: tpg_out = k after edge E0+k, k=0..63; increments by 1 per cycle; no wrap into a second pass.
//  - Expected value: exp = popcount(tpg_out), 3 bits, pipelined DUT_LAT stages.
//    - A valid bit travels the same delay line.
//    - DUT_LAT==0: compare in the same cycle, combinationally.
//  - Compare: at each edge where the delayed valid bit is set:
//    - If dut_resp != exp_d: err_cnt+1.
//    - On the first such mismatch, first_fail <= pattern_d.
//  - Completion: last compare at edge E0+64+DUT_LAT. The same edge enters DONE:
//    - done=1, busy=0, test_mode=0.
//    - pass computed from the final counts.
//  - err_cnt cannot exceed 64; no saturation logic needed.
//  - start while busy: ignored. start held high in DONE: relaunches every time DONE is reached.
//  - Reset mid-run: immediate return to reset values; no partial results retained.
//  - tpg_out holds 63 during DRAIN and returns to 0 in IDLE/DONE.
// CONFIGURATION
//  BIST_MISR_EN defined:
//   - Two 3-bit MISRs, poly x^3+x+1; each steps on valid compare cycles.
//   - Next state for input r: {s[1], s[0]^s[2], s[2]} ^ r.
//   - DUT MISR compacts dut_resp; reference MISR compacts exp_d.
//   - signature = DUT MISR.
//   - pass = (err_cnt==0) && (DUT MISR == ref MISR).
//  BIST_MISR_EN undefined: no MISR logic; signature tied 3'b000; pass = (err_cnt==0).
// STRUCTURE
//  Package bist_pkg:
//   - FSM state enum {IDLE,RUN,DRAIN,DONE}.
//   - Constants N_IN=6, N_OUT=3, N_PAT=64, MISR_POLY=3'b011.
//  Sub-module bist_misr:
//   - 3-bit MISR with clr and en.
//   - Instantiated twice under BIST_MISR_EN.
//  Golden popcount and the delay line stay inline in bist_counter_ctrl.
// TESTING (bench drives dut_resp from a behavioural counter model with DUT_LAT delay)
//  1. Fault-free model, DUT_LAT=1, start pulse at E0
//     -> busy from E0; done at E0+65; pass=1; err_cnt=0; first_fail=0.
//  2. Sum bit stuck-at-0 -> err_cnt=32; first_fail=6'h01; pass=0.
//  3. dut_resp forced 3'b111 -> err_cnt=64; first_fail=6'h00; pass=0.
//  4. rst pulsed while tpg_out==20
//     -> all outputs 0 asynchronously; new start completes a clean run with pass=1.
//  5. start re-asserted at tpg_out==10 -> ignored; done still at E0+65; results identical to case 1.
//  6. BIST_MISR_EN, DUT_LAT=0, fault-free
//     -> done at E0+64; signature equals reference MISR; pass=1.
//     Single flipped response on pattern 6'h2A -> err_cnt=1; first_fail=6'h2A.

Source files
------------

// File: rtl/bist_pkg.sv
// Package: bist_pkg
// Shared types and constants for the 6:3 counter BIST controller.
//   - bist_state_e : controller FSM states
//   - N_IN / N_OUT : width of the counter under test (6 inputs, 3-bit count)
//   - N_PAT        : number of exhaustive test patterns
//   - MISR_POLY    : feedback taps of the x^3+x+1 MISR
//   - popcount6()  : golden model of the 6:3 counter
package bist_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } bist_state_e;

   localparam int N_IN  = 6;
   localparam int N_OUT = 3;
   localparam int N_PAT = 64;

   localparam logic [N_OUT-1:0] MISR_POLY = 3'b011;

   // The counter under test must produce the number of ones in its 6-bit input.
   function automatic logic [N_OUT-1:0] popcount6(input logic [N_IN-1:0] v);
      logic [N_OUT-1:0] c;
      c = '0;
      for (int i = 0; i < N_IN; i++) begin
         c = c + N_OUT'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/bist_misr.sv
// Module: bist_misr
// 3-bit multiple-input signature register, polynomial x^3+x+1.
// Ports:
//   clk  in  1  rising-edge clock
//   rst  in  1  asynchronous active-high reset
//   clr  in  1  synchronous clear (wins over en)
//   en   in  1  compact din into the signature this cycle
//   din  in  3  response word to compact
//   sig  out 3  current signature
module bist_misr
   import bist_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [N_OUT-1:0] din,
   output logic [N_OUT-1:0] sig
);

   logic [N_OUT-1:0] sig_q;
   logic [N_OUT-1:0] sig_d;

   // Shift left and fold the outgoing msb back through the polynomial taps,
   // which works out to {s[1], s[0]^s[2], s[2]} ^ din.
   always_comb begin
      sig_d = sig_q;
      if (clr) begin
         sig_d = '0;
      end else if (en) begin
         sig_d = {sig_q[N_OUT-2:0], 1'b0} ^ (sig_q[N_OUT-1] ? MISR_POLY : '0) ^ din;
      end
   end

   // Signature register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/bist_counter_ctrl.sv
// Module: bist_counter_ctrl
// BIST controller for the fast 6:3 counter. On an accepted start it walks all
// 64 input patterns through the counter, checks every response against an
// internal popcount model delayed by DUT_LAT cycles, and reports pass/fail,
// the error count and the first failing pattern.
// Optional feature macro: BIST_MISR_EN adds DUT and reference MISRs; pass then
// also requires matching signatures. Without it signature is tied to zero.
// Parameters:
//   DUT_LAT  cycles from tpg_out change to valid dut_resp (0..4)
// Ports:
//   clk         in   1  rising-edge clock
//   rst         in   1  asynchronous active-high reset
//   start       in   1  launches a run when sampled in IDLE or DONE
//   dut_resp    in   3  {carry2,carry1,sum} from the counter under test
//   test_mode   out  1  steers tpg_out into the counter while busy
//   tpg_out     out  6  current test pattern
//   busy        out  1  run in progress
//   done        out  1  run finished, held until the next accepted start
//   pass        out  1  run finished with no errors (and matching signatures)
//   err_cnt     out  7  number of mismatching responses
//   first_fail  out  6  pattern of the first mismatch, 0 if none
//   signature   out  3  DUT MISR value (0 without BIST_MISR_EN)
module bist_counter_ctrl
   import bist_pkg::*;
#(
   parameter int DUT_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N_OUT-1:0] dut_resp,
   output logic             test_mode,
   output logic [N_IN-1:0]  tpg_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [6:0]       err_cnt,
   output logic [N_IN-1:0]  first_fail,
   output logic [N_OUT-1:0] signature
);

   localparam logic [2:0] DRAIN_LAST = (DUT_LAT > 0) ? 3'(DUT_LAT - 1) : 3'd0;

   bist_state_e      state_q, state_d;
   logic [N_IN-1:0]  pattern_q, pattern_d;
   logic [2:0]       drain_q, drain_d;
   logic [6:0]       err_cnt_q, err_cnt_d;
   logic [N_IN-1:0]  first_fail_q, first_fail_d;

   logic             start_acc;
   logic             vld_now;
   logic [N_OUT-1:0] exp_now;
   logic             vld_dly;
   logic [N_OUT-1:0] exp_dly;
   logic [N_IN-1:0]  pat_dly;
   logic             mismatch;
   logic             sig_match;

   assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));
   assign vld_now   = (state_q == RUN);
   assign exp_now   = popcount6(pattern_q);

   // Next state and pattern counter. The counter is cleared on every entry to
   // DONE so tpg_out reads 0 outside a run without extra output gating.
   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      drain_d   = drain_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = RUN;
               pattern_d = '0;
            end
         end
         RUN: begin
            if (pattern_q == N_IN'(N_PAT - 1)) begin
               if (DUT_LAT == 0) begin
                  state_d   = DONE;
                  pattern_d = '0;
               end else begin
                  state_d = DRAIN;
                  drain_d = '0;
               end
            end else begin
               pattern_d = pattern_q + 1'b1;
            end
         end
         DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               state_d   = DONE;
               pattern_d = '0;
            end else begin
               drain_d = drain_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM, pattern and drain counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pattern_q <= '0;
         drain_q   <= '0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         drain_q   <= drain_d;
      end
   end

   // Expected value, pattern and valid flag travel together so each compare
   // lines up with the response the counter gives DUT_LAT cycles later.
   generate
      if (DUT_LAT == 0) begin : g_no_pipe
         assign exp_dly = exp_now;
         assign pat_dly = pattern_q;
         assign vld_dly = vld_now;
      end else begin : g_pipe
         logic [N_OUT-1:0] exp_pipe_q [DUT_LAT];
         logic [N_IN-1:0]  pat_pipe_q [DUT_LAT];
         logic             vld_pipe_q [DUT_LAT];

         // Shift register, stage 0 fed from the current pattern.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DUT_LAT; i++) begin
                  exp_pipe_q[i] <= '0;
                  pat_pipe_q[i] <= '0;
                  vld_pipe_q[i] <= 1'b0;
               end
            end else begin
               exp_pipe_q[0] <= exp_now;
               pat_pipe_q[0] <= pattern_q;
               vld_pipe_q[0] <= vld_now;
               for (int i = 1; i < DUT_LAT; i++) begin
                  exp_pipe_q[i] <= exp_pipe_q[i-1];
                  pat_pipe_q[i] <= pat_pipe_q[i-1];
                  vld_pipe_q[i] <= vld_pipe_q[i-1];
               end
            end
         end

         assign exp_dly = exp_pipe_q[DUT_LAT-1];
         assign pat_dly = pat_pipe_q[DUT_LAT-1];
         assign vld_dly = vld_pipe_q[DUT_LAT-1];
      end
   endgenerate

   assign mismatch = vld_dly && (dut_resp != exp_dly);

   // Result accumulation. The pipeline is empty whenever start can be
   // accepted, so clear and count never compete.
   always_comb begin
      err_cnt_d    = err_cnt_q;
      first_fail_d = first_fail_q;
      if (start_acc) begin
         err_cnt_d    = '0;
         first_fail_d = '0;
      end else if (mismatch) begin
         err_cnt_d = err_cnt_q + 7'd1;
         if (err_cnt_q == 7'd0) begin
            first_fail_d = pat_dly;
         end
      end
   end

   // Result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q    <= '0;
         first_fail_q <= '0;
      end else begin
         err_cnt_q    <= err_cnt_d;
         first_fail_q <= first_fail_d;
      end
   end

`ifdef BIST_MISR_EN
   logic [N_OUT-1:0] dut_sig;
   logic [N_OUT-1:0] ref_sig;

   bist_misr u_dut_misr (
      .clk (clk),
      .rst (rst),
      .clr (start_acc),
      .en  (vld_dly),
      .din (dut_resp),
      .sig (dut_sig)
   );

   bist_misr u_ref_misr (
      .clk (clk),
      .rst (rst),
      .clr (start_acc),
      .en  (vld_dly),
      .din (exp_dly),
      .sig (ref_sig)
   );

   assign signature = dut_sig;
   assign sig_match = (dut_sig == ref_sig);
`else
   assign signature = '0;
   assign sig_match = 1'b1;
`endif

   assign busy       = (state_q == RUN) || (state_q == DRAIN);
   assign test_mode  = busy;
   assign done       = (state_q == DONE);
   assign tpg_out    = pattern_q;
   assign err_cnt    = err_cnt_q;
   assign first_fail = first_fail_q;
   // Pass reflects the final counts, which are already registered on the edge
   // that enters DONE.
   assign pass       = done && (err_cnt_q == 7'd0) && sig_match;

endmodule

// File: tb/tb_bist_counter_ctrl.sv
// Testbench for bist_counter_ctrl. Two controllers run side by side: one with
// DUT_LAT=0 and one with DUT_LAT=1, each fed by a behavioural 6:3 counter model
// with selectable faults.
module tb_bist_counter_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       test_mode;
      logic [5:0] tpg;
      logic       busy;
      logic       done;
      logic       pass;
      logic [6:0] err;
      logic [5:0] ff;
      logic [2:0] sig;
   } obs_t;

   typedef struct {
      int inst;
      int fault;
      int restart_at;
      int exp_err;
      int exp_ff;
      int exp_pass;
      int exp_cycles;
   } vec_t;

   logic       start0, start1;
   logic [2:0] resp0, resp1;
   int         fault0, fault1;
   obs_t       obs0, obs1;
   logic [5:0] hist1;

   int n_checks = 0;
   int n_mis    = 0;

   bist_counter_ctrl #(.DUT_LAT(0)) u_dut0 (
      .clk        (clk),
      .rst        (rst),
      .start      (start0),
      .dut_resp   (resp0),
      .test_mode  (obs0.test_mode),
      .tpg_out    (obs0.tpg),
      .busy       (obs0.busy),
      .done       (obs0.done),
      .pass       (obs0.pass),
      .err_cnt    (obs0.err),
      .first_fail (obs0.ff),
      .signature  (obs0.sig)
   );

   bist_counter_ctrl #(.DUT_LAT(1)) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .start      (start1),
      .dut_resp   (resp1),
      .test_mode  (obs1.test_mode),
      .tpg_out    (obs1.tpg),
      .busy       (obs1.busy),
      .done       (obs1.done),
      .pass       (obs1.pass),
      .err_cnt    (obs1.err),
      .first_fail (obs1.ff),
      .signature  (obs1.sig)
   );

   // Behavioural counter: ones count of the pattern, optionally corrupted.
   // 1 sum stuck-at-0, 2 output forced 111, 3/4/5 sum flipped on 2A/3F/00.
   function automatic logic [2:0] modelResp(input logic [5:0] pat, input int fault);
      logic [2:0] pc;
      pc = 3'd0;
      for (int i = 0; i < 6; i++) pc = pc + 3'(pat[i]);
      case (fault)
         1: return pc & 3'b110;
         2: return 3'b111;
         3: return (pat == 6'h2A) ? (pc ^ 3'b001) : pc;
         4: return (pat == 6'h3F) ? (pc ^ 3'b001) : pc;
         5: return (pat == 6'h00) ? (pc ^ 3'b001) : pc;
         default: return pc;
      endcase
   endfunction

   // Signature the DUT MISR should hold after compacting all 64 responses.
   function automatic logic [2:0] expSig(input int fault);
      logic [2:0] s;
      logic [2:0] r;
      s = 3'd0;
      for (int k = 0; k < 64; k++) begin
         r = modelResp(6'(k), fault);
         s = {s[1], s[0] ^ s[2], s[2]} ^ r;
      end
      return s;
   endfunction

   always @(posedge clk) hist1 <= obs1.tpg;
   always_comb resp0 = modelResp(obs0.tpg, fault0);
   always_comb resp1 = modelResp(hist1, fault1);

   function automatic obs_t getObs(input int inst);
      return (inst != 0) ? obs1 : obs0;
   endfunction

   task automatic setStart(input int inst, input logic v);
      if (inst != 0) start1 = v;
      else start0 = v;
   endtask

   task automatic setFault(input int inst, input int f);
      if (inst != 0) fault1 = f;
      else fault0 = f;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_mis++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One full run: start pulse, optional start re-assertion while busy, wait
   // for done with a cycle budget, tracking tpg_out against its schedule.
   task automatic applyStimulus(input int inst, input int fault, input int restart_at,
                                input string tag, output int cycles);
      obs_t o;
      int   lat;
      int   exp_tpg;
      bit   tpg_ok;
      lat = (inst != 0) ? 1 : 0;
      setFault(inst, fault);
      @(negedge clk);
      setStart(inst, 1'b1);
      @(posedge clk);
      #1;
      setStart(inst, 1'b0);
      o = getObs(inst);
      checkOutput({tag, "_busy_at_start"}, 32'(o.busy), 32'd1);
      checkOutput({tag, "_tmode_at_start"}, 32'(o.test_mode), 32'd1);
      checkOutput({tag, "_cleared_at_start"}, {o.tpg, o.done, o.pass, o.err, o.ff}, 32'd0);
      cycles = 0;
      tpg_ok = 1'b1;
      while (!o.done && cycles < 200) begin
         @(posedge clk);
         #1;
         cycles++;
         o = getObs(inst);
         if (cycles <= 63) exp_tpg = cycles;
         else if (cycles < 64 + lat) exp_tpg = 63;
         else exp_tpg = 0;
         if (o.tpg !== 6'(exp_tpg)) tpg_ok = 1'b0;
         if (restart_at >= 0) begin
            setStart(inst, o.busy && (int'(o.tpg) >= restart_at) && (int'(o.tpg) < restart_at + 3));
         end
      end
      setStart(inst, 1'b0);
      checkOutput({tag, "_tpg_sequence"}, 32'(tpg_ok), 32'd1);
   endtask

   vec_t vecs [10];

   initial begin
      obs_t o;
      int   cycles;
      logic [2:0] exp_sig;
      string tag;

      vecs[0] = '{1, 0, -1,  0, 8'h00, 1, 65};
      vecs[1] = '{1, 1, -1, 32, 8'h01, 0, 65};
      vecs[2] = '{1, 2, -1, 64, 8'h00, 0, 65};
      vecs[3] = '{1, 0, 10,  0, 8'h00, 1, 65};
      vecs[4] = '{1, 5, -1,  1, 8'h00, 0, 65};
      vecs[5] = '{1, 4, -1,  1, 8'h3F, 0, 65};
      vecs[6] = '{0, 0, -1,  0, 8'h00, 1, 64};
      vecs[7] = '{0, 3, -1,  1, 8'h2A, 0, 64};
      vecs[8] = '{0, 1, 30, 32, 8'h01, 0, 64};
      vecs[9] = '{0, 2, -1, 64, 8'h00, 0, 64};

      rst = 1'b1;
      start0 = 1'b0;
      start1 = 1'b0;
      fault0 = 0;
      fault1 = 0;
      #2;
      checkOutput("reset_lat0", 32'(obs0), 32'd0);
      checkOutput("reset_lat1", 32'(obs1), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle_lat1", 32'(obs1), 32'd0);

      for (int i = 0; i < 10; i++) begin
         tag = $sformatf("v%0d", i);
         applyStimulus(vecs[i].inst, vecs[i].fault, vecs[i].restart_at, tag, cycles);
         o = getObs(vecs[i].inst);
`ifdef BIST_MISR_EN
         exp_sig = expSig(vecs[i].fault);
`else
         exp_sig = 3'b000;
`endif
         checkOutput({tag, "_done_cycle"}, 32'(cycles), 32'(vecs[i].exp_cycles));
         checkOutput({tag, "_err_cnt"}, 32'(o.err), 32'(vecs[i].exp_err));
         checkOutput({tag, "_first_fail"}, 32'(o.ff), 32'(vecs[i].exp_ff));
         checkOutput({tag, "_pass"}, 32'(o.pass), 32'(vecs[i].exp_pass));
         checkOutput({tag, "_idle_flags"}, {o.busy, o.test_mode, o.tpg}, 32'd0);
         checkOutput({tag, "_signature"}, 32'(o.sig), 32'(exp_sig));
      end

      // Reset in the middle of a faulty run, then a clean run afterwards.
      setFault(1, 2);
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      cycles = 0;
      while (obs1.tpg != 6'd20 && cycles < 100) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput("rst_reach_tpg20", 32'(obs1.tpg), 32'd20);
      checkOutput("rst_errs_before", 32'(obs1.err != 7'd0), 32'd1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_async_clear", 32'(obs1), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1, 0, -1, "post_rst", cycles);
      checkOutput("post_rst_done_cycle", 32'(cycles), 32'd65);
      checkOutput("post_rst_pass", 32'(obs1.pass), 32'd1);
      checkOutput("post_rst_err_cnt", 32'(obs1.err), 32'd0);

      // start held high: DONE must relaunch on the following edge.
      setFault(0, 0);
      @(negedge clk);
      start0 = 1'b1;
      cycles = 0;
      do begin
         @(posedge clk);
         #1;
         cycles++;
      end while (!obs0.done && cycles < 200);
      checkOutput("hold_first_done", 32'(obs0.done), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("hold_relaunch", {obs0.busy, obs0.done, obs0.tpg}, {24'd0, 2'b10, 6'd0});
      start0 = 1'b0;
      cycles = 0;
      while (!obs0.done && cycles < 200) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput("hold_second_cycles", 32'(cycles), 32'd64);
      checkOutput("hold_second_pass", 32'(obs0.pass), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_mis);
      $finish;
   end

endmodule
